regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports (1..4).
REQ-004 SHALL have parameter DBG_REG, default 10: index of the register mirrored on dbg_data (a0).
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-007 SHALL have port rs_addr  input  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rs_data  output  NUM_RD*DATA_W  read data, packed as for rs_addr.
REQ-009 SHALL have port rs_busy  output  NUM_RD  per-port pending-write flag.
REQ-010 SHALL have port hazard  output  1  OR of rs_busy.
REQ-011 SHALL have port issue_en  input  1  claims register issue_rd for a future write.
REQ-012 SHALL have port issue_rd  input  ADDR_W  register being claimed.
REQ-013 SHALL have port we  input  1  writeback enable.
REQ-014 SHALL have port wr_rd  input  ADDR_W  writeback destination.
REQ-015 SHALL have port wr_data  input  DATA_W  writeback data.
REQ-016 SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently busy.
REQ-017 SHALL have port dbg_data  output  DATA_W  contents of register DBG_REG.

Function
REQ-018 SHALL return register contents combinationally on every read port; zero-latency read.
REQ-019 SHALL return 0 for address 0 and report rs_busy=0 for address 0, regardless of writes or issues.
REQ-020 SHALL, on a clock edge with we=1 and wr_rd!=0, store wr_data to wr_rd; we=1 with wr_rd=0 has no effect.
REQ-021 SHALL keep one busy bit per register; issue_en=1 with issue_rd!=0 sets busy[issue_rd] on the next edge.
REQ-022 SHALL clear busy[wr_rd] on a clock edge with we=1 and wr_rd!=0.
REQ-023 SHALL, when issue and writeback target the same register on the same edge, leave busy set (issue wins) and still write the data.
REQ-024 SHALL treat issue_en to an already-busy register as a no-op on the busy bit (no nesting count).
REQ-025 SHALL update busy_cnt registered alongside busy bits: +1 on a new set, -1 on a clear, net 0 when both occur on different registers, never wrapping (range 0..2**ADDR_W-1).
REQ-026 SHALL drive dbg_data combinationally from register DBG_REG, obeying REQ-019 and REQ-033.
REQ-027 SHALL drive rs_busy[i] combinationally as busy[rs_addr[i]], with the bypass adjustment of REQ-033 when enabled.

Reset
REQ-028 SHALL, on an edge with rst=1, clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-029 SHALL give rst priority over we and issue_en on the same edge; both are discarded.
REQ-030 SHALL output, during and after reset until the first write, rs_data=0, rs_busy=0, hazard=0, dbg_data=0.
REQ-031 SHALL abandon outstanding claims on mid-operation reset; a later writeback to a non-busy register still writes data and leaves busy_cnt at 0.

Configuration
REQ-032 SHALL compile write-to-read bypass only when macro REGFILE_SB_BYPASS_EN is defined.
REQ-033 SHALL, with REGFILE_SB_BYPASS_EN defined, return wr_data on any read port (and dbg_data) whose address equals wr_rd while we=1 and wr_rd!=0, and force that port's rs_busy to 0 unless issue_en targets the same register in that cycle.
REQ-034 SHALL, without REGFILE_SB_BYPASS_EN, return pre-edge register contents and busy state in the writeback cycle (write visible the cycle after).

Verification
REQ-035 SHALL be covered by: rst=1 one cycle -> all rs_data=0, hazard=0, busy_cnt=0, dbg_data=0.
REQ-036 SHALL be covered by: we=1, wr_rd=0, wr_data=0xDEADBEEF; then read address 0 -> rs_data=0; write x10=0x00000042 -> dbg_data=0x00000042 next cycle.
REQ-037 SHALL be covered by: issue_rd=5; next cycle rs_addr port0=5 -> rs_busy[0]=1, hazard=1, busy_cnt=1; we=1 wr_rd=5 wr_data=7 -> next cycle rs_data=7, rs_busy=0, busy_cnt=0.
REQ-038 SHALL be covered by: x6 busy; same edge issue_rd=6 and we wr_rd=6 wr_data=9 -> x6 reads 9, busy stays 1, busy_cnt unchanged.
REQ-039 SHALL be covered by: with REGFILE_SB_BYPASS_EN, we wr_rd=3 wr_data=0x11 while rs_addr port1=3 -> same-cycle rs_data port1=0x11, rs_busy[1]=0; without macro -> old value that cycle, 0x11 next.
REQ-040 SHALL be covered by: three registers busy, rst=1 with we and issue_en asserted -> busy_cnt=0, all registers 0, neither write nor issue takes effect.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Register file with a per-register scoreboard busy bit and a count.
//            Optional same-cycle write-to-read bypass: define REGFILE_SB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int DBG_REG = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  output logic                     hazard,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_rd,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [ADDR_W:0]          busy_cnt,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic w_wr_en;
  logic w_iss_en;
  logic w_set;
  logic w_clr;

  assign w_wr_en  = we && (wr_rd != '0);
  assign w_iss_en = issue_en && (issue_rd != '0);
  // A new claim only counts if the bit was clear; a writeback to the register
  // being claimed on the same edge loses to the claim.
  assign w_set    = w_iss_en && !busy_q[issue_rd];
  assign w_clr    = w_wr_en && busy_q[wr_rd] && !(w_iss_en && (issue_rd == wr_rd));

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (w_wr_en) begin
      regs_d[wr_rd] = wr_data;
      busy_d[wr_rd] = 1'b0;
    end
    if (w_iss_en) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (w_set && !w_clr) begin
      busy_cnt_d = busy_cnt_q + CNT_ONE;
    end else if (w_clr && !w_set) begin
      busy_cnt_d = busy_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Register 0 is never written or claimed, so plain indexing reads it as 0.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rs_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_SB_BYPASS_EN
    logic hit;
    assign hit = w_wr_en && (addr == wr_rd);
    assign rs_data[i*DATA_W +: DATA_W] = hit ? wr_data : regs_q[addr];
    assign rs_busy[i] = hit ? (w_iss_en && (issue_rd == wr_rd) && busy_q[addr])
                            : busy_q[addr];
`else
    assign rs_data[i*DATA_W +: DATA_W] = regs_q[addr];
    assign rs_busy[i] = busy_q[addr];
`endif
  end

`ifdef REGFILE_SB_BYPASS_EN
  assign dbg_data = (w_wr_en && (wr_rd == DBG_IDX)) ? wr_data : regs_q[DBG_IDX];
`else
  assign dbg_data = regs_q[DBG_IDX];
`endif

  assign hazard   = |rs_busy;
  assign busy_cnt = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed self-checking bench for regfile_sb (DATA_W=32, ADDR_W=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        hazard;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        we;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [5:0]  busy_cnt;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .DBG_REG(10)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data),
    .rs_busy(rs_busy), .hazard(hazard), .issue_en(issue_en),
    .issue_rd(issue_rd), .we(we), .wr_rd(wr_rd), .wr_data(wr_data),
    .busy_cnt(busy_cnt), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; issue_en = 0; wr_rd = 0; issue_rd = 0; wr_data = 0;
  endtask

  task automatic test_reset();
    idle(); rs_addr = {5'd1, 5'd0};
    rst = 1; tick(); rst = 0; #1;
    checks++; if (rs_data !== 64'h0) begin errors++; $display("FAIL reset_rs_data got %h exp 0", rs_data); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", hazard); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt got %0d exp 0", busy_cnt); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg got %h exp 0", dbg_data); end
  endtask

  task automatic test_zero_reg();
    we = 1; wr_rd = 0; wr_data = 32'hDEADBEEF; issue_en = 1; issue_rd = 0;
    tick(); idle(); rs_addr = {5'd10, 5'd0}; #1;
    checks++; if (rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL x0_data got %h exp 0", rs_data[31:0]); end
    checks++; if (rs_busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy got %b exp 0", rs_busy[0]); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL x0_cnt got %0d exp 0", busy_cnt); end
    we = 1; wr_rd = 10; wr_data = 32'h00000042;
    tick(); idle(); #1;
    checks++; if (dbg_data !== 32'h00000042) begin errors++; $display("FAIL dbg_x10 got %h exp 00000042", dbg_data); end
    checks++; if (rs_data[63:32] !== 32'h00000042) begin errors++; $display("FAIL rd1_x10 got %h exp 00000042", rs_data[63:32]); end
  endtask

  task automatic test_issue_writeback();
    issue_en = 1; issue_rd = 5; tick(); idle(); rs_addr = {5'd0, 5'd5}; #1;
    checks++; if (rs_busy !== 2'b01) begin errors++; $display("FAIL iss_busy got %b exp 01", rs_busy); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL iss_hazard got %b exp 1", hazard); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL iss_cnt got %0d exp 1", busy_cnt); end
    we = 1; wr_rd = 5; wr_data = 32'd7; #1;
`ifndef REGFILE_SB_BYPASS_EN
    checks++; if (rs_data[31:0] !== 32'd0 || rs_busy[0] !== 1'b1) begin errors++; $display("FAIL wb_cycle_old got %h/%b exp 0/1", rs_data[31:0], rs_busy[0]); end
`endif
    tick(); idle(); #1;
    checks++; if (rs_data[31:0] !== 32'd7) begin errors++; $display("FAIL wb_data got %h exp 7", rs_data[31:0]); end
    checks++; if (rs_busy !== 2'b00 || hazard !== 1'b0) begin errors++; $display("FAIL wb_busy got %b/%b exp 00/0", rs_busy, hazard); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL wb_cnt got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_same_edge();
    issue_en = 1; issue_rd = 6; tick(); idle();
    issue_en = 1; issue_rd = 6; we = 1; wr_rd = 6; wr_data = 32'd9;
    tick(); idle(); rs_addr = {5'd0, 5'd6}; #1;
    checks++; if (rs_data[31:0] !== 32'd9) begin errors++; $display("FAIL same_data got %h exp 9", rs_data[31:0]); end
    checks++; if (rs_busy[0] !== 1'b1) begin errors++; $display("FAIL same_busy got %b exp 1", rs_busy[0]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL same_cnt got %0d exp 1", busy_cnt); end
    issue_en = 1; issue_rd = 6; tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL reissue_cnt got %0d exp 1", busy_cnt); end
    we = 1; wr_rd = 6; wr_data = 32'd1; tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd0 || rs_busy[0] !== 1'b0) begin errors++; $display("FAIL single_clear got %0d/%b exp 0/0", busy_cnt, rs_busy[0]); end
  endtask

  task automatic test_back_to_back();
    issue_en = 1; issue_rd = 7; tick(); idle();
    issue_en = 1; issue_rd = 8; we = 1; wr_rd = 7; wr_data = 32'h77;
    tick(); idle(); rs_addr = {5'd8, 5'd7}; #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL net0_cnt got %0d exp 1", busy_cnt); end
    checks++; if (rs_busy !== 2'b10) begin errors++; $display("FAIL net0_busy got %b exp 10", rs_busy); end
    checks++; if (rs_data[31:0] !== 32'h77) begin errors++; $display("FAIL net0_data got %h exp 77", rs_data[31:0]); end
    we = 1; wr_rd = 8; wr_data = 32'h88; tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd0 || rs_data[63:32] !== 32'h88) begin errors++; $display("FAIL x8_clear got %0d/%h exp 0/88", busy_cnt, rs_data[63:32]); end
  endtask

  task automatic test_bypass();
    rs_addr = {5'd3, 5'd0};
    we = 1; wr_rd = 3; wr_data = 32'h11; #1;
`ifdef REGFILE_SB_BYPASS_EN
    checks++; if (rs_data[63:32] !== 32'h11 || rs_busy[1] !== 1'b0) begin errors++; $display("FAIL byp_same got %h/%b exp 11/0", rs_data[63:32], rs_busy[1]); end
`else
    checks++; if (rs_data[63:32] !== 32'h0) begin errors++; $display("FAIL nobyp_same got %h exp 0", rs_data[63:32]); end
`endif
    tick(); idle(); #1;
    checks++; if (rs_data[63:32] !== 32'h11) begin errors++; $display("FAIL byp_next got %h exp 11", rs_data[63:32]); end
  endtask

  task automatic test_reset_mid();
    issue_en = 1; issue_rd = 12; tick();
    issue_rd = 13; tick();
    issue_rd = 14; tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL pre_rst_cnt got %0d exp 3", busy_cnt); end
    rst = 1; we = 1; wr_rd = 15; wr_data = 32'h55; issue_en = 1; issue_rd = 16;
    tick(); idle(); rs_addr = {5'd15, 5'd12}; #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", busy_cnt); end
    checks++; if (rs_data !== 64'h0 || rs_busy !== 2'b00) begin errors++; $display("FAIL rst_regs got %h/%b exp 0/00", rs_data, rs_busy); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL rst_dbg got %h exp 0", dbg_data); end
    rs_addr = {5'd16, 5'd3}; #1;
    checks++; if (rs_busy[1] !== 1'b0 || rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL rst_discard got %b/%h exp 0/0", rs_busy[1], rs_data[31:0]); end
    we = 1; wr_rd = 12; wr_data = 32'hAB; tick(); idle(); rs_addr = {5'd0, 5'd12}; #1;
    checks++; if (rs_data[31:0] !== 32'hAB) begin errors++; $display("FAIL post_rst_wb got %h exp ab", rs_data[31:0]); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL post_rst_cnt got %0d exp 0", busy_cnt); end
  endtask

  initial begin
    idle(); rs_addr = '0;
    test_reset();
    test_zero_reg();
    test_issue_writeback();
    test_same_edge();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
